// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the seven-segment display blocks.
//   seg7_t        : 7-bit active-low segment vector, bit 6 = a ... bit 0 = g
//   SEG_HEX_0..F  : active-low patterns for the hex digits 0-F
//   SEG_BLANK     : all segments dark
// ---------------------------------------------------------------------------
package seg_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_HEX_0 = 7'b0000001;
    localparam seg7_t SEG_HEX_1 = 7'b1001111;
    localparam seg7_t SEG_HEX_2 = 7'b0010010;
    localparam seg7_t SEG_HEX_3 = 7'b0000110;
    localparam seg7_t SEG_HEX_4 = 7'b1001100;
    localparam seg7_t SEG_HEX_5 = 7'b0100100;
    localparam seg7_t SEG_HEX_6 = 7'b0100000;
    localparam seg7_t SEG_HEX_7 = 7'b0001111;
    localparam seg7_t SEG_HEX_8 = 7'b0000000;
    localparam seg7_t SEG_HEX_9 = 7'b0000100;
    localparam seg7_t SEG_HEX_A = 7'b0001000;
    localparam seg7_t SEG_HEX_B = 7'b1100000;
    localparam seg7_t SEG_HEX_C = 7'b0110001;
    localparam seg7_t SEG_HEX_D = 7'b1000010;
    localparam seg7_t SEG_HEX_E = 7'b0110000;
    localparam seg7_t SEG_HEX_F = 7'b0111000;

    localparam seg7_t SEG_BLANK = 7'h7F;

endpackage

// File: rtl/hex_to_seg.sv
// ---------------------------------------------------------------------------
// hex_to_seg
// Purely combinational hex nibble to seven-segment decoder (active-low).
//   hex_i : 4-bit value to display
//   seg_o : active-low segments, seg_o[6]=a ... seg_o[0]=g
// ---------------------------------------------------------------------------
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] hex_i,
    output seg7_t      seg_o
);

    // Straight table lookup; the default only exists to keep the decode
    // obviously latch-free.
    always_comb begin
        seg_o = SEG_BLANK;
        case (hex_i)
            4'h0:    seg_o = SEG_HEX_0;
            4'h1:    seg_o = SEG_HEX_1;
            4'h2:    seg_o = SEG_HEX_2;
            4'h3:    seg_o = SEG_HEX_3;
            4'h4:    seg_o = SEG_HEX_4;
            4'h5:    seg_o = SEG_HEX_5;
            4'h6:    seg_o = SEG_HEX_6;
            4'h7:    seg_o = SEG_HEX_7;
            4'h8:    seg_o = SEG_HEX_8;
            4'h9:    seg_o = SEG_HEX_9;
            4'hA:    seg_o = SEG_HEX_A;
            4'hB:    seg_o = SEG_HEX_B;
            4'hC:    seg_o = SEG_HEX_C;
            4'hD:    seg_o = SEG_HEX_D;
            4'hE:    seg_o = SEG_HEX_E;
            4'hF:    seg_o = SEG_HEX_F;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
// Multiplexed seven-segment scan controller with per-frame input snapshot,
// PWM brightness, forced blanking and leading-zero blanking.
//   clk, rst     : clock (rising edge), synchronous active-high reset
//   digits_i     : hex value per digit, digit k at [4k+3:4k]
//   dp_i         : decimal point request per digit (1 = lit)
//   blank_i      : forced blank per digit (1 = dark)
//   lz_blank_i   : leading-zero blanking enable
//   bright_i     : brightness code
//   seg_o, dp_o  : active-low segments / decimal point
//   an_o         : active-low anodes, at most one low
//   frame_o      : one-cycle pulse after the last slot of each scan
// ---------------------------------------------------------------------------
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int TICK_DIV   = 100000,
    parameter int BRIGHT_W   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   blank_i,
    input  logic                    lz_blank_i,
    input  logic [BRIGHT_W-1:0]     bright_i,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_o
);

    // Reject illegal parameterisations while elaborating.
    if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : gBadDigits
        $error("seg_scan_ctrl: NUM_DIGITS must be 1..16");
    end
    if (TICK_DIV < 4) begin : gBadTickDiv
        $error("seg_scan_ctrl: TICK_DIV must be at least 4");
    end
    if (BRIGHT_W < 1 || BRIGHT_W > 8) begin : gBadBrightW
        $error("seg_scan_ctrl: BRIGHT_W must be 1..8");
    end

    localparam int CNT_W  = $clog2(TICK_DIV);
    localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TICK_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [SLOT_W-1:0]       slot_q, slot_d;
    logic                    cntWrap, slotWrap, frameEnd;

    logic [4*NUM_DIGITS-1:0] digitsSnap_q;
    logic [NUM_DIGITS-1:0]   dpSnap_q;
    logic [NUM_DIGITS-1:0]   blankSnap_q;
    logic                    lzSnap_q;
    logic [CNT_W-1:0]        onCycles_q, onCycles_d;

    logic [63:0]             brightProd, brightScaled;
    logic [3:0]              digitArr [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   darkVec;
    logic                    allZeroAbove;
    logic [3:0]              curNibble;
    seg7_t                   decodedSeg;
    logic                    lit;

    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_q, frame_d;

    // Prescaler and slot sequencing: the slot only moves when the prescaler
    // wraps, and the last cycle of the last slot marks the frame end.
    always_comb begin
        cntWrap  = (cnt_q == CNT_MAX);
        slotWrap = (slot_q == SLOT_MAX);
        frameEnd = cntWrap && slotWrap;
        cnt_d    = cntWrap ? '0 : cnt_q + CNT_W'(1);
        slot_d   = slot_q;
        if (cntWrap) begin
            slot_d = slotWrap ? '0 : slot_q + SLOT_W'(1);
        end
    end

    // Lit window length for the next frame. 64-bit arithmetic cannot
    // overflow for any legal parameter set; the result is clipped so the
    // cnt==0 anti-ghost gap always survives.
    always_comb begin
        brightProd   = (64'(bright_i) + 64'd1) * 64'(TICK_DIV);
        brightScaled = brightProd >> BRIGHT_W;
        if (brightScaled > 64'(TICK_DIV - 1)) begin
            onCycles_d = CNT_MAX;
        end else begin
            onCycles_d = brightScaled[CNT_W-1:0];
        end
    end

    // Per-digit darkness from the snapshot. Walking from the top digit down,
    // a digit is a leading zero while it and everything above it are zero.
    always_comb begin
        allZeroAbove = 1'b1;
        darkVec      = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            digitArr[k]  = digitsSnap_q[4*k +: 4];
            allZeroAbove = allZeroAbove && (digitsSnap_q[4*k +: 4] == 4'h0);
            darkVec[k]   = blankSnap_q[k] || (lzSnap_q && (k != 0) && allZeroAbove);
        end
    end

    assign curNibble = digitArr[slot_q];

    hex_to_seg uDecode (
        .hex_i (curNibble),
        .seg_o (decodedSeg)
    );

    // Output selection for the current cnt/slot; only the slot's own anode
    // can ever go low, so at most one anode is active in any cycle.
    always_comb begin
        lit     = !darkVec[slot_q] && (cnt_q != '0) && (cnt_q <= onCycles_q);
        an_d    = '1;
        seg_d   = SEG_BLANK;
        dp_d    = 1'b1;
        frame_d = frameEnd;
        if (lit) begin
            an_d[slot_q] = 1'b0;
            seg_d        = decodedSeg;
            dp_d         = ~dpSnap_q[slot_q];
        end
    end

    // Scan counters and registered outputs. Reset drops everything dark
    // immediately, so a reset mid-slot cannot leave a partial pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            slot_q  <= '0;
            an_q    <= '1;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            frame_q <= frame_d;
        end
    end

    // Snapshot registers. Resetting blank to all-ones keeps the first frame
    // after reset dark; new inputs only land at a frame end.
    always_ff @(posedge clk) begin
        if (rst) begin
            digitsSnap_q <= '0;
            dpSnap_q     <= '0;
            blankSnap_q  <= '1;
            lzSnap_q     <= 1'b0;
            onCycles_q   <= '0;
        end else if (frameEnd) begin
            digitsSnap_q <= digits_i;
            dpSnap_q     <= dp_i;
            blankSnap_q  <= blank_i;
            lzSnap_q     <= lz_blank_i;
            onCycles_q   <= onCycles_d;
        end
    end

    assign seg_o   = seg_q;
    assign dp_o    = dp_q;
    assign an_o    = an_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Self-checking bench for seg_scan_ctrl (4 digits, TICK_DIV 4, 2-bit
// brightness). A time-based model predicts every output each cycle; directed
// scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int TD    = 4;
    localparam int BW    = 2;
    localparam int FRAME = ND * TD;

    localparam logic [6:0] SEGTAB [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    logic        clk;
    logic        rst;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lz;
    logic [1:0]  bright;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic [3:0]  an_o;
    logic        frame_o;

    int nCompared   = 0;
    int nMismatched = 0;
    bit checkEn     = 0;

    int         mt;
    logic [15:0] mDigits;
    logic [3:0]  mDp, mBlank;
    logic        mLz;
    logic [1:0]  mBright;
    logic [3:0]  eAn;
    logic [6:0]  eSeg;
    logic        eDp, eFrame;

    int         scanLows [4];
    logic [6:0] scanSegs [4];

    seg_scan_ctrl #(
        .NUM_DIGITS (ND),
        .TICK_DIV   (TD),
        .BRIGHT_W   (BW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits_i   (digits),
        .dp_i       (dp),
        .blank_i    (blank),
        .lz_blank_i (lz),
        .bright_i   (bright),
        .seg_o      (seg_o),
        .dp_o       (dp_o),
        .an_o       (an_o),
        .frame_o    (frame_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Which digit (if any) is lit when t cycles have elapsed since reset,
    // worked out from elapsed time and the model snapshot alone.
    function automatic int litDigit(input int t);
        int c, s, on;
        bit dark;
        c  = t % TD;
        s  = (t / TD) % ND;
        on = ((int'(mBright) + 1) * TD) >> BW;
        if (on > TD - 1) on = TD - 1;
        dark = mBlank[s] || (mLz && s > 0 && (mDigits >> (4 * s)) == 16'h0);
        return (!dark && c >= 1 && c <= on) ? s : -1;
    endfunction

    function automatic logic [3:0] expAn(input int t);
        int k = litDigit(t);
        return (k < 0) ? 4'hF : (4'hF & ~(4'b0001 << k));
    endfunction

    function automatic logic [6:0] expSeg(input int t);
        int k = litDigit(t);
        logic [3:0] nib;
        if (k < 0) return 7'h7F;
        nib = mDigits[4*k +: 4];
        return SEGTAB[nib];
    endfunction

    function automatic logic expDp(input int t);
        int k = litDigit(t);
        return (k < 0) ? 1'b1 : ~mDp[k];
    endfunction

    // Reference model: outputs registered one cycle after the time slot
    // they describe; the snapshot refreshes on the last cycle of a frame.
    always @(posedge clk) begin
        if (rst) begin
            mt      <= 0;
            mDigits <= '0;
            mDp     <= '0;
            mBlank  <= '1;
            mLz     <= 1'b0;
            mBright <= '0;
            eAn     <= 4'hF;
            eSeg    <= 7'h7F;
            eDp     <= 1'b1;
            eFrame  <= 1'b0;
        end else begin
            eAn    <= expAn(mt);
            eSeg   <= expSeg(mt);
            eDp    <= expDp(mt);
            eFrame <= (mt % FRAME) == FRAME - 1;
            if ((mt % FRAME) == FRAME - 1) begin
                mDigits <= digits;
                mDp     <= dp;
                mBlank  <= blank;
                mLz     <= lz;
                mBright <= bright;
            end
            mt <= mt + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model an_o",    32'(an_o),    32'(eAn));
            checkOutput("model seg_o",   32'(seg_o),   32'(eSeg));
            checkOutput("model dp_o",    32'(dp_o),    32'(eDp));
            checkOutput("model frame_o", 32'(frame_o), 32'(eFrame));
        end
    end

    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] p,
                                 input logic [3:0] b, input logic l,
                                 input logic [1:0] br);
        digits = d;
        dp     = p;
        blank  = b;
        lz     = l;
        bright = br;
    endtask

    // Waits for the next frame_o pulse, bounded to a little over two frames.
    task automatic waitFrame();
        bit seen = 0;
        for (int i = 0; i < 2 * FRAME + 2 && !seen; i++) begin
            @(negedge clk);
            if (frame_o === 1'b1) seen = 1;
        end
        nCompared++;
        if (!seen) begin
            nMismatched++;
            $display("[TB] FAIL frame pulse timeout: got none, expected one within %0d cycles", 2 * FRAME + 2);
        end
    endtask

    // Starting right after a pulse, watch one frame and record per-slot
    // anode-low counts and the segments shown at cnt==1.
    task automatic scanFrame();
        for (int s = 0; s < ND; s++) begin
            scanLows[s] = 0;
            scanSegs[s] = 7'h7F;
        end
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (an_o[i / TD] == 1'b0) scanLows[i / TD]++;
            if (i % TD == 1) scanSegs[i / TD] = seg_o;
        end
    endtask

    task automatic checkLows(input string name, input logic [15:0] expLows);
        for (int s = 0; s < ND; s++) begin
            checkOutput(name, 32'(scanLows[s]), 32'(expLows[4*s +: 4]));
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        nMismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int frames;
        rst = 1'b1;
        applyStimulus(16'h3210, 4'h0, 4'h0, 1'b0, 2'd3);
        @(posedge clk);
        checkEn = 1;

        // Reset held for three cycles.
        repeat (3) @(negedge clk);
        checkOutput("reset an_o",    32'(an_o),    32'hF);
        checkOutput("reset seg_o",   32'(seg_o),   32'h7F);
        checkOutput("reset dp_o",    32'(dp_o),    32'h1);
        checkOutput("reset frame_o", 32'(frame_o), 32'h0);
        rst = 1'b0;

        // The first frame after reset is dark; its last cycle carries the pulse.
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            checkOutput("first frame dark", 32'(an_o), 32'hF);
        end
        checkOutput("first frame pulse", 32'(frame_o), 32'h1);

        // Frame 2 shows 3210 at brightness 3: each anode low 3 of 4 cycles.
        scanFrame();
        checkLows("scan lows", 16'h3333);
        checkOutput("scan seg 0", 32'(scanSegs[0]), 32'h01);
        checkOutput("scan seg 1", 32'(scanSegs[1]), 32'h4F);
        checkOutput("scan seg 2", 32'(scanSegs[2]), 32'h12);
        checkOutput("scan seg 3", 32'(scanSegs[3]), 32'h06);

        // Brightness codes 0 and 1.
        applyStimulus(16'h3210, 4'h0, 4'h0, 1'b0, 2'd0);
        waitFrame();
        scanFrame();
        checkLows("bright0 lows", 16'h1111);
        applyStimulus(16'h3210, 4'h0, 4'h0, 1'b0, 2'd1);
        waitFrame();
        scanFrame();
        checkLows("bright1 lows", 16'h2222);

        // Leading-zero and forced blanking.
        applyStimulus(16'h0050, 4'h0, 4'h0, 1'b1, 2'd3);
        waitFrame();
        scanFrame();
        checkLows("lz 0050 lows", 16'h0033);
        checkOutput("lz 0050 seg 0", 32'(scanSegs[0]), 32'h01);
        checkOutput("lz 0050 seg 1", 32'(scanSegs[1]), 32'h24);
        applyStimulus(16'h0000, 4'h0, 4'h0, 1'b1, 2'd3);
        waitFrame();
        scanFrame();
        checkLows("lz 0000 lows", 16'h0003);
        applyStimulus(16'h0000, 4'h0, 4'h1, 1'b1, 2'd3);
        waitFrame();
        scanFrame();
        checkLows("blank0 lows", 16'h0000);

        // Mid-frame input change stays invisible until the next frame.
        applyStimulus(16'h3210, 4'b0101, 4'h0, 1'b0, 2'd3);
        waitFrame();
        repeat (6) @(negedge clk);
        applyStimulus(16'hABCD, 4'b1010, 4'h0, 1'b0, 2'd3);
        repeat (8) @(negedge clk);
        checkOutput("snapshot old an",  32'(an_o),  32'h7);
        checkOutput("snapshot old seg", 32'(seg_o), 32'h06);
        checkOutput("snapshot old dp",  32'(dp_o),  32'h1);
        frames = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (frame_o === 1'b1) frames++;
        end
        checkOutput("frame pulses per 16", 32'(frames), 32'd1);
        checkOutput("snapshot new seg", 32'(seg_o), 32'h08);
        checkOutput("snapshot new dp",  32'(dp_o),  32'h0);

        // Randomised traffic, changes landing at arbitrary frame phases.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ($urandom_range(3) == 0) begin
                applyStimulus(16'($urandom) >> (4 * $urandom_range(3)),
                              4'($urandom),
                              ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0,
                              1'($urandom),
                              2'($urandom));
            end
        end

        // Reset during a lit slot 2.
        applyStimulus(16'h3210, 4'h0, 4'h0, 1'b0, 2'd3);
        waitFrame();
        repeat (10) @(negedge clk);
        checkOutput("pre-reset slot2 an", 32'(an_o), 32'hB);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid reset an_o",    32'(an_o),    32'hF);
        checkOutput("mid reset seg_o",   32'(seg_o),   32'h7F);
        checkOutput("mid reset frame_o", 32'(frame_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            checkOutput("post reset dark", 32'(an_o), 32'hF);
        end
        repeat (2) @(negedge clk);
        checkOutput("restart slot0 an",  32'(an_o),  32'hE);
        checkOutput("restart slot0 seg", 32'(seg_o), 32'h01);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
